rbt_s_parser_rr_arbiter: RTL
============================

Name: rbt_s_parser_rr_arbiter

Overview:
- Shares one transport-layer parser instance among NUM_SRC proto-header requesters.
- Round-robin arbitration feeds one registered beat per cycle to the parser input.
- Each accepted beat's source ID is recorded in an in-order tag FIFO.
- The FIFO head steers each parser result back to the requester that issued it.
- Sits between the per-port header extractors and the parser stage, inside the parser pipeline.

Parameters:
NUM_SRC, 4, number of requesters (2..8)
HEADER_WIDTH, 2048, header data bus width (multiple of 8)
PHV_WIDTH, 408, PHV bus width
TAG_DEPTH, 4, tag FIFO depth (power of 2, >=2) = max beats in flight (output register + parser + output)
SRC_W, $clog2(NUM_SRC), source ID width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_proto_hdr_valid  in  NUM_SRC  per-requester valid
in_proto_hdr_ready  out  NUM_SRC  per-requester ready
in_proto_hdr_length  in  16*NUM_SRC  lengths, source i at [16*i +: 16]
in_proto_hdr_data  in  HEADER_WIDTH*NUM_SRC  headers, source i at [HEADER_WIDTH*i +: HEADER_WIDTH]
in_proto_hdr_phv  in  PHV_WIDTH*NUM_SRC  PHVs, source i at [PHV_WIDTH*i +: PHV_WIDTH]
par_hdr_valid  out  1  to parser
par_hdr_ready  in  1  from parser
par_hdr_length / par_hdr_data / par_hdr_phv  out  16 / HEADER_WIDTH / PHV_WIDTH  registered beat to parser
res_hdr_valid  in  1  parser result valid
res_hdr_ready  out  1  parser result ready
res_hdr_length / res_hdr_data / res_hdr_phv  in  16 / HEADER_WIDTH / PHV_WIDTH  parser result
out_proto_hdr_valid  out  NUM_SRC  per-requester result valid
out_proto_hdr_ready  in  NUM_SRC  per-requester result ready
out_proto_hdr_length / out_proto_hdr_data / out_proto_hdr_phv  out  16 / HEADER_WIDTH / PHV_WIDTH  shared result bus, combinational pass-through of res_*
out_src_id  out  SRC_W  FIFO head (destination of current result)
inflight_count  out  $clog2(TAG_DEPTH+1)  tag FIFO occupancy
err_orphan  out  1  sticky: result arrived with tag FIFO empty

Behaviour:

Reset:
- Single clock; reset asynchronous, active-low.
- On rst_n=0: par_hdr_valid=0, par_* data regs=0, tag FIFO empty, inflight_count=0, err_orphan=0.
- On rst_n=0: last_grant=NUM_SRC-1, so input 0 has first priority.
- Reset mid-operation discards the held beat and all tags; the parser must be reset in the same domain.

Acceptance:
- accept = (!par_hdr_valid | par_hdr_ready) & !fifo_full.
- full blocks a push even when a pop occurs in the same cycle.

Grant:
- Combinational: first valid input searching from last_grant+1 upward, wrapping modulo NUM_SRC.
- in_proto_hdr_ready[i] = accept & (grant==i) & any_valid.
- Ready never depends on the requester's own valid beyond grant selection; at most one ready is high per cycle.

On handshake of grant g:
- Load par_* registers from source g; par_hdr_valid<=1.
- Push g into the tag FIFO; last_grant<=g.
- Latency from input handshake to par_hdr_valid is 1 cycle.
- Back-to-back beats from different sources sustain 1 beat/cycle when par_hdr_ready=1.

No grant while accept=1:
- If par_hdr_ready=1 (or the register is already empty), par_hdr_valid<=0.
- last_grant is unchanged.

Register stability:
- par_* registers hold steady while par_hdr_valid & !par_hdr_ready.

Return path:
- out_src_id = FIFO head.
- out_proto_hdr_valid[i] = res_hdr_valid & !fifo_empty & (head==i).
- res_hdr_ready = !fifo_empty & out_proto_hdr_ready[head].
- A result handshake pops the FIFO.

Orphan result (res_hdr_valid with FIFO empty):
- Force res_hdr_ready=1, which drops the beat.
- Set err_orphan (cleared only by reset).
- No out valid is raised.

FIFO counters:
- Simultaneous push and pop: count unchanged; pointers wrap modulo TAG_DEPTH.
- inflight_count = count, range 0..TAG_DEPTH.

Ordering:
- The parser is required to be in-order; per-source ordering is preserved end to end.

Test Plan:
- Reset, then all 4 inputs valid continuously, par/out ready=1 -> grants in order 0,1,2,3,0,1...; out_src_id follows the same sequence 1 cycle behind the parser latency; inflight_count steady at 2.
- Only input 2 valid, 3 beats (lengths 0x40,0x41,0x42) -> 3 consecutive grants to 2; results arrive on out_proto_hdr_valid[2] only, lengths in order.
- par_hdr_ready=0 for 5 cycles with inputs 1,3 valid -> one beat held stable in par_* (source 1); in_proto_hdr_ready all 0 while held; input 3 granted on the cycle ready returns.
- out_proto_hdr_ready[head]=0 with TAG_DEPTH=4 -> FIFO fills to 4; in_proto_hdr_ready all 0; inflight_count=4; on release, pop and push resume with no loss.
- Pulse res_hdr_valid with FIFO empty -> res_hdr_ready=1, no out valid, err_orphan=1 until rst_n low.
- Assert rst_n=0 mid-burst with 3 in flight -> par_hdr_valid=0 and inflight_count=0 immediately (async); first grant after release goes to input 0.

Source files
------------

// File: rtl/rbt_s_parser_rr_arbiter_if.sv
// Bundled handshake buses around the shared parser arbiter: requester side, parser side,
// parser-result side and the steered result fan-out back to the requesters.
interface rbt_s_parser_rr_arbiter_if #(
    parameter int NUM_SRC      = 4,
    parameter int HEADER_WIDTH = 2048,
    parameter int PHV_WIDTH    = 408,
    parameter int TAG_DEPTH    = 4
);
    localparam int SRC_W = $clog2(NUM_SRC);
    localparam int CNT_W = $clog2(TAG_DEPTH + 1);

    logic [NUM_SRC-1:0]              in_proto_hdr_valid;
    logic [NUM_SRC-1:0]              in_proto_hdr_ready;
    logic [16*NUM_SRC-1:0]           in_proto_hdr_length;
    logic [HEADER_WIDTH*NUM_SRC-1:0] in_proto_hdr_data;
    logic [PHV_WIDTH*NUM_SRC-1:0]    in_proto_hdr_phv;

    logic                    par_hdr_valid;
    logic                    par_hdr_ready;
    logic [15:0]             par_hdr_length;
    logic [HEADER_WIDTH-1:0] par_hdr_data;
    logic [PHV_WIDTH-1:0]    par_hdr_phv;

    logic                    res_hdr_valid;
    logic                    res_hdr_ready;
    logic [15:0]             res_hdr_length;
    logic [HEADER_WIDTH-1:0] res_hdr_data;
    logic [PHV_WIDTH-1:0]    res_hdr_phv;

    logic [NUM_SRC-1:0]      out_proto_hdr_valid;
    logic [NUM_SRC-1:0]      out_proto_hdr_ready;
    logic [15:0]             out_proto_hdr_length;
    logic [HEADER_WIDTH-1:0] out_proto_hdr_data;
    logic [PHV_WIDTH-1:0]    out_proto_hdr_phv;
    logic [SRC_W-1:0]        out_src_id;
    logic [CNT_W-1:0]        inflight_count;
    logic                    err_orphan;

    modport slave (
        input  in_proto_hdr_valid, in_proto_hdr_length, in_proto_hdr_data, in_proto_hdr_phv,
        output in_proto_hdr_ready,
        output par_hdr_valid, par_hdr_length, par_hdr_data, par_hdr_phv,
        input  par_hdr_ready,
        input  res_hdr_valid, res_hdr_length, res_hdr_data, res_hdr_phv,
        output res_hdr_ready,
        output out_proto_hdr_valid, out_proto_hdr_length, out_proto_hdr_data, out_proto_hdr_phv,
        input  out_proto_hdr_ready,
        output out_src_id, inflight_count, err_orphan
    );

    modport master (
        output in_proto_hdr_valid, in_proto_hdr_length, in_proto_hdr_data, in_proto_hdr_phv,
        input  in_proto_hdr_ready,
        input  par_hdr_valid, par_hdr_length, par_hdr_data, par_hdr_phv,
        output par_hdr_ready,
        output res_hdr_valid, res_hdr_length, res_hdr_data, res_hdr_phv,
        input  res_hdr_ready,
        input  out_proto_hdr_valid, out_proto_hdr_length, out_proto_hdr_data, out_proto_hdr_phv,
        output out_proto_hdr_ready,
        input  out_src_id, inflight_count, err_orphan
    );
endinterface

// File: rtl/rbt_s_parser_rr_arbiter.sv
// Round-robin share of one parser among NUM_SRC requesters; an in-order tag FIFO
// remembers who issued each beat so parser results are steered back to their owner.
module rbt_s_parser_rr_arbiter_lane #(
    parameter int SRC_W = 2,
    parameter int LANE  = 0
) (
    input  logic [SRC_W-1:0] grant,
    input  logic [SRC_W-1:0] head,
    input  logic             push,
    input  logic             res_live,
    output logic             in_ready,
    output logic             out_valid
);
    assign in_ready  = push && (grant == SRC_W'(LANE));
    assign out_valid = res_live && (head == SRC_W'(LANE));
endmodule

module rbt_s_parser_rr_arbiter #(
    parameter int NUM_SRC      = 4,
    parameter int HEADER_WIDTH = 2048,
    parameter int PHV_WIDTH    = 408,
    parameter int TAG_DEPTH    = 4,
    parameter int SRC_W        = $clog2(NUM_SRC)
) (
    input  logic clk,
    input  logic rst_n,
    rbt_s_parser_rr_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = $clog2(TAG_DEPTH + 1);

    logic [SRC_W-1:0] last_grant;
    logic [SRC_W-1:0] grant;
    logic [SRC_W-1:0] head;
    logic             any_valid;
    logic             accept;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic             res_live;
    logic             res_ready;

    logic [SRC_W-1:0] tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic                    par_valid_q;
    logic [15:0]             par_len_q;
    logic [HEADER_WIDTH-1:0] par_data_q;
    logic [PHV_WIDTH-1:0]    par_phv_q;
    logic                    err_q;

    logic [NUM_SRC-1:0] in_ready_v;
    logic [NUM_SRC-1:0] out_valid_v;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = last_grant;
        any_valid = 1'b0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            idx = int'(last_grant) + i;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            if (!any_valid && bus.in_proto_hdr_valid[SRC_W'(idx)]) begin
                any_valid = 1'b1;
                grant     = SRC_W'(idx);
            end
        end
    end

    assign fifo_full  = (count == CNT_W'(TAG_DEPTH));
    assign fifo_empty = (count == '0);
    // A full FIFO blocks the push even if a result pops in the same cycle.
    assign accept     = (!par_valid_q || bus.par_hdr_ready) && !fifo_full;
    assign push       = accept && any_valid;

    assign head       = tag_mem[rd_ptr];
    assign res_live   = bus.res_hdr_valid && !fifo_empty;
    // With no tag outstanding the result has no owner: swallow it and flag it.
    assign res_ready  = fifo_empty ? 1'b1 : bus.out_proto_hdr_ready[head];
    assign pop        = res_live && res_ready;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
        rbt_s_parser_rr_arbiter_lane #(
            .SRC_W (SRC_W),
            .LANE  (i)
        ) u_lane (
            .grant     (grant),
            .head      (head),
            .push      (push),
            .res_live  (res_live),
            .in_ready  (in_ready_v[i]),
            .out_valid (out_valid_v[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant  <= SRC_W'(NUM_SRC - 1);
            par_valid_q <= 1'b0;
            par_len_q   <= '0;
            par_data_q  <= '0;
            par_phv_q   <= '0;
        end else if (push) begin
            last_grant  <= grant;
            par_valid_q <= 1'b1;
            par_len_q   <= bus.in_proto_hdr_length[16*int'(grant) +: 16];
            par_data_q  <= bus.in_proto_hdr_data[HEADER_WIDTH*int'(grant) +: HEADER_WIDTH];
            par_phv_q   <= bus.in_proto_hdr_phv[PHV_WIDTH*int'(grant) +: PHV_WIDTH];
        end else if (bus.par_hdr_ready) begin
            // Also covers a full FIFO: the consumed beat must not be presented twice.
            par_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_ptr] <= grant;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err_q  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (bus.res_hdr_valid && fifo_empty) err_q <= 1'b1;
        end
    end

    assign bus.in_proto_hdr_ready   = in_ready_v;
    assign bus.par_hdr_valid        = par_valid_q;
    assign bus.par_hdr_length       = par_len_q;
    assign bus.par_hdr_data         = par_data_q;
    assign bus.par_hdr_phv          = par_phv_q;
    assign bus.res_hdr_ready        = res_ready;
    assign bus.out_proto_hdr_valid  = out_valid_v;
    assign bus.out_proto_hdr_length = bus.res_hdr_length;
    assign bus.out_proto_hdr_data   = bus.res_hdr_data;
    assign bus.out_proto_hdr_phv    = bus.res_hdr_phv;
    assign bus.out_src_id           = head;
    assign bus.inflight_count       = count;
    assign bus.err_orphan           = err_q;
endmodule
